memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum cycles to wait for mem_ack_i before an error is flagged (legal range 1..255).
REQ-002 SHALL have the following ports, each listed as name, direction, width, meaning:
- clk_i  in  1  single clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  instruction valid for the memory stage; sampled only in IDLE.
- icode_i  in  4  instruction code, using the codebase encoding: IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
- valE_i  in  64  ALU result from the execute stage.
- valA_i  in  64  register operand A.
- valP_i  in  64  next-PC value (return address for call).
- valM_o  out  64  read data, registered.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in any state other than IDLE.
- dmem_error_o  out  1  error flag, valid while done_o is high.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  64  bus address.
- mem_wdata_o  out  64  bus write data.
- mem_rdata_i  in  64  bus read data.
- mem_ack_i  in  1  bus acknowledge.
- mem_err_i  in  1  bus error, qualified by mem_ack_i.

Function
REQ-003 SHALL implement an FSM with three states: IDLE, REQ and DONE.
REQ-004 When start_i=1 in IDLE, SHALL capture the operands and decode icode_i as follows:
- Address is valE_i for 4, 5, 8 and A; address is valA_i for 9 and B.
- The operation is a write for 4 and A (data = valA_i) and for 8 (data = valP_i).
- The operation is a read for 5, 9 and B.
REQ-005 A memory icode SHALL move IDLE->REQ; any other icode SHALL move IDLE->DONE with no bus activity.
REQ-006 In REQ, SHALL hold mem_req_o=1 with mem_addr_o, mem_we_o and mem_wdata_o stable until the cycle in which mem_ack_i=1.
REQ-007 On ack for a read with mem_err_i=0, SHALL latch mem_rdata_i into valM_o.
REQ-008 On ack, SHALL move REQ->DONE and drop mem_req_o in the following cycle.
REQ-009 Latency from start_i to done_o SHALL be:
- 1 cycle for non-memory icodes;
- (ack-wait + 2) cycles for memory icodes, where a same-cycle ack (mem_ack_i high in the first REQ cycle) gives 2 cycles.
REQ-010 done_o SHALL be high for exactly one cycle in DONE, then the FSM SHALL move DONE->IDLE.
REQ-011 start_i SHALL be ignored while busy_o=1, with no queuing.
REQ-012 A 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-013 When the wait counter reaches TIMEOUT_CYCLES without ack, SHALL drop mem_req_o, move to DONE and set dmem_error_o=1.
REQ-014 A timeout SHALL be evaluated before an ack arriving in the same cycle, and the late ack SHALL be ignored.
REQ-015 An ack with mem_err_i=1 SHALL set dmem_error_o=1 and leave valM_o unchanged.
REQ-016 dmem_error_o SHALL be 0 for non-memory icodes and for successful accesses.
REQ-017 valM_o SHALL hold its last value until the next successful read, including across writes and errors.
REQ-018 mem_addr_o and mem_wdata_o SHALL be driven to 0 when mem_req_o=0.

Reset
REQ-019 rst_n_i=0 SHALL asynchronously force the FSM to IDLE and clear valM_o, done_o, dmem_error_o, mem_req_o, mem_we_o and the wait counter to 0.
REQ-020 Reset asserted mid-REQ SHALL drop mem_req_o in the same cycle, abandon the access and produce no done_o pulse.
REQ-021 The first start_i SHALL be accepted on the first rising edge after reset is released.

Configuration
REQ-022 Macro MEM_ALIGN_CHECK_EN controls the alignment check.
REQ-023 With MEM_ALIGN_CHECK_EN defined, a memory icode with address[2:0]!=0 SHALL go IDLE->DONE with dmem_error_o=1 and no bus request.
REQ-024 Without MEM_ALIGN_CHECK_EN, the address SHALL be issued unmodified regardless of alignment.

Verification
REQ-025 Read with same-cycle ack: icode=5, valE=0x100, start_i pulse, ack with rdata=0xDEADBEEF -> mem_req_o=1, we=0, addr=0x100; done_o 2 cycles after start; valM_o=0xDEADBEEF; err=0.
REQ-026 Call write with delayed ack: icode=8, valE=0x1F8, valP=0x42, ack after 3 wait cycles -> we=1, addr=0x1F8, wdata=0x42 held stable for 4 cycles; done_o at start+5.
REQ-027 Non-memory bypass: icode=6, start_i -> done_o the next cycle, mem_req_o never asserted, valM_o unchanged.
REQ-028 Bus error and timeout:
- icode=B, valA=0x80, ack with mem_err_i=1 -> dmem_error_o=1, valM_o unchanged.
- TIMEOUT_CYCLES=4, no ack -> done_o with err=1 after 4 REQ cycles.
REQ-029 Reset and start during busy: rst_n_i low during REQ -> mem_req_o=0 immediately, no done_o; start_i pulsed during REQ is ignored (exactly one done_o per accepted start).
REQ-030 Alignment check: with MEM_ALIGN_CHECK_EN defined, icode=4, valE=0x103 -> no request, done_o next cycle with err=1; without the macro, a request to 0x103 is issued.

Source files
------------

// File: rtl/memory_access.sv
// memory_access -- memory stage of the Y86-64 style pipeline.
//
// Takes one instruction when idle, decodes it and runs at most one bus
// transaction. Completion is a one-cycle done_o pulse, with dmem_error_o
// valid in that cycle.
//
// Parameters
//   TIMEOUT_CYCLES : REQ cycles allowed without an ack before the access is
//                    abandoned with an error. Legal range is 1..255.
//
// Configuration macro
//   MEM_ALIGN_CHECK_EN : when defined, a memory access whose address is not
//                        8-byte aligned finishes immediately with an error
//                        and puts nothing on the bus. When undefined, the
//                        address goes to the bus unmodified.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   start_i                 instruction valid; sampled only while idle
//   icode_i                 instruction code (4,5,8,9,A,B use memory)
//   valE_i, valA_i, valP_i  ALU result, operand A, next PC
//   valM_o                  last successfully read data (registered)
//   done_o                  one-cycle completion pulse
//   busy_o                  high whenever not idle
//   dmem_error_o            error flag, valid while done_o is high
//   mem_req_o, mem_we_o     bus request, 1 = write
//   mem_addr_o, mem_wdata_o bus address / write data (0 when no request)
//   mem_rdata_i             bus read data
//   mem_ack_i, mem_err_i    bus ack, bus error (qualified by ack)
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  output logic [63:0] valM_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        dmem_error_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i,
  input  logic        mem_ack_i,
  input  logic        mem_err_i
);

  localparam int unsigned DATA_W = 64;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Last count value tolerated: the REQ cycle in which the counter would
  // reach TIMEOUT_CYCLES is the timeout cycle, checked ahead of any ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [7:0]        wait_q, wait_d;
  logic [DATA_W-1:0] valm_q, valm_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Instruction decode
  logic              dec_mem;
  logic              dec_wr;
  logic [DATA_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_wdata;
  logic              dec_misaligned;

  always_comb begin
    dec_mem   = 1'b0;
    dec_wr    = 1'b0;
    dec_addr  = '0;
    dec_wdata = '0;
    case (icode_i)
      IRMMOVQ: begin dec_mem = 1'b1; dec_wr = 1'b1; dec_addr = valE_i; dec_wdata = valA_i; end
      IMRMOVQ: begin dec_mem = 1'b1; dec_addr = valE_i; end
      ICALL:   begin dec_mem = 1'b1; dec_wr = 1'b1; dec_addr = valE_i; dec_wdata = valP_i; end
      IRET:    begin dec_mem = 1'b1; dec_addr = valA_i; end
      IPUSHQ:  begin dec_mem = 1'b1; dec_wr = 1'b1; dec_addr = valE_i; dec_wdata = valA_i; end
      IPOPQ:   begin dec_mem = 1'b1; dec_addr = valA_i; end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign dec_misaligned = dec_mem && (dec_addr[2:0] != 3'b000);
`else
  assign dec_misaligned = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    wait_d  = wait_q;
    valm_d  = valm_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (dec_mem && !dec_misaligned) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = dec_wr;
            addr_d  = dec_addr;
            wdata_d = dec_wdata;
            wait_d  = 8'd0;
            err_d   = 1'b0;
          end else begin
            // Non-memory bypass, or a rejected misaligned access.
            state_d = S_DONE;
            err_d   = dec_misaligned;
          end
        end
      end
      S_REQ: begin
        if (wait_q == WAIT_LAST) begin
          // Timeout wins over an ack arriving in the same cycle.
          state_d = S_DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else if (mem_ack_i) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          err_d   = mem_err_i;
          if (!we_q && !mem_err_i) begin
            valm_d = mem_rdata_i;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Control and architecturally visible state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wait_q  <= 8'd0;
      valm_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
    end
  end

  // Bus address/data holding registers; outputs are gated by req_q.
  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign valM_o       = valm_q;
  assign done_o       = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign dmem_error_o = err_q;
  assign mem_req_o    = req_q;
  assign mem_we_o     = req_q & we_q;
  assign mem_addr_o   = req_q ? addr_q  : '0;
  assign mem_wdata_o  = req_q ? wdata_q : '0;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_to = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [63:0] valE = '0, valA = '0, valP = '0;
  logic [63:0] rdata = '0;
  logic        ack = 1'b0, berr = 1'b0;

  logic [63:0] valM, addr, wdata;
  logic        done, busy, derr, req, we;

  logic [63:0] to_valM, to_addr, to_wdata;
  logic        to_done, to_busy, to_derr, to_req, to_we;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .icode_i(icode),
    .valE_i(valE), .valA_i(valA), .valP_i(valP),
    .valM_o(valM), .done_o(done), .busy_o(busy), .dmem_error_o(derr),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_rdata_i(rdata), .mem_ack_i(ack), .mem_err_i(berr)
  );

  memory_access #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_to), .icode_i(icode),
    .valE_i(valE), .valA_i(valA), .valP_i(valP),
    .valM_o(to_valM), .done_o(to_done), .busy_o(to_busy), .dmem_error_o(to_derr),
    .mem_req_o(to_req), .mem_we_o(to_we), .mem_addr_o(to_addr), .mem_wdata_o(to_wdata),
    .mem_rdata_i(rdata), .mem_ack_i(ack), .mem_err_i(berr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_err", 64'(derr), 64'd0);
    chk("rst_addr", addr, 64'd0);
    rst_n = 1'b1;

    // Read, same-cycle ack
    icode = 4'h5; valE = 64'h100; start = 1'b1;
    tick(); start = 1'b0;
    chk("rd_req", 64'(req), 64'd1);
    chk("rd_we", 64'(we), 64'd0);
    chk("rd_addr", addr, 64'h100);
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_done_early", 64'(done), 64'd0);
    ack = 1'b1; rdata = 64'hDEADBEEF;
    tick(); ack = 1'b0;
    chk("rd_done", 64'(done), 64'd1);
    chk("rd_valM", valM, 64'hDEADBEEF);
    chk("rd_err", 64'(derr), 64'd0);
    chk("rd_req_drop", 64'(req), 64'd0);
    chk("rd_addr_zero", addr, 64'd0);
    tick();
    chk("rd_done_pulse", 64'(done), 64'd0);
    chk("rd_idle", 64'(busy), 64'd0);

    // Call write, ack after 3 wait cycles
    icode = 4'h8; valE = 64'h1F8; valP = 64'h42; valA = 64'h999; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("call_req", 64'(req), 64'd1);
      chk("call_we", 64'(we), 64'd1);
      chk("call_addr", addr, 64'h1F8);
      chk("call_wdata", wdata, 64'h42);
      chk("call_nodone", 64'(done), 64'd0);
      if (i == 4) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    chk("call_done", 64'(done), 64'd1);
    chk("call_err", 64'(derr), 64'd0);
    chk("call_valM_kept", valM, 64'hDEADBEEF);
    chk("call_wdata_zero", wdata, 64'd0);
    tick();

    // Non-memory bypass
    icode = 4'h6; start = 1'b1;
    tick(); start = 1'b0;
    chk("nm_done", 64'(done), 64'd1);
    chk("nm_req", 64'(req), 64'd0);
    chk("nm_err", 64'(derr), 64'd0);
    chk("nm_valM", valM, 64'hDEADBEEF);
    tick();
    chk("nm_idle", 64'(busy), 64'd0);

    // Bus error on popq
    icode = 4'hB; valA = 64'h80; valE = 64'h555; start = 1'b1;
    tick(); start = 1'b0;
    chk("pop_addr", addr, 64'h80);
    chk("pop_we", 64'(we), 64'd0);
    ack = 1'b1; berr = 1'b1; rdata = 64'h1234;
    tick(); ack = 1'b0; berr = 1'b0;
    chk("pop_done", 64'(done), 64'd1);
    chk("pop_err", 64'(derr), 64'd1);
    chk("pop_valM_kept", valM, 64'hDEADBEEF);
    tick();
    chk("pop_err_clear", 64'(derr), 64'd0);

    // Timeout, TIMEOUT_CYCLES=4, no ack
    icode = 4'h5; valE = 64'h200; start_to = 1'b1;
    tick(); start_to = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("to_req", 64'(to_req), 64'd1);
      chk("to_nodone", 64'(to_done), 64'd0);
      tick();
    end
    chk("to_done", 64'(to_done), 64'd1);
    chk("to_err", 64'(to_derr), 64'd1);
    chk("to_req_drop", 64'(to_req), 64'd0);
    tick();
    chk("to_done_pulse", 64'(to_done), 64'd0);

    // Timeout beats an ack in the same cycle
    icode = 4'h5; valE = 64'h208; rdata = 64'hCAFE; start_to = 1'b1;
    tick(); start_to = 1'b0;
    tick(); tick(); tick();
    chk("late_req", 64'(to_req), 64'd1);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("late_done", 64'(to_done), 64'd1);
    chk("late_err", 64'(to_derr), 64'd1);
    chk("late_valM", to_valM, 64'd0);
    tick();

    // start_i ignored while busy
    icode = 4'h5; valE = 64'h300; start = 1'b1;
    tick();
    icode = 4'h6;
    tick();
    chk("busy_req", 64'(req), 64'd1);
    chk("busy_addr", addr, 64'h300);
    tick(); start = 1'b0;
    ack = 1'b1; rdata = 64'h77;
    tick(); ack = 1'b0;
    chk("busy_done", 64'(done), 64'd1);
    chk("busy_valM", valM, 64'h77);
    tick();
    chk("busy_no_second_done", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);

    // Reset mid-REQ
    icode = 4'h5; valE = 64'h400; start = 1'b1;
    tick(); start = 1'b0;
    chk("mr_req", 64'(req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req_async", 64'(req), 64'd0);
    chk("mr_valM_clr", valM, 64'd0);
    tick();
    chk("mr_no_done", 64'(done), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    icode = 4'h5; valE = 64'h500; start = 1'b1;
    rst_n = 1'b1;
    tick(); start = 1'b0;
    chk("mr_first_start", 64'(busy), 64'd1);
    chk("mr_first_addr", addr, 64'h500);
    ack = 1'b1; rdata = 64'h55;
    tick(); ack = 1'b0;
    chk("mr_done", 64'(done), 64'd1);
    chk("mr_valM", valM, 64'h55);
    tick();

    // Misaligned address
    icode = 4'h4; valE = 64'h103; valA = 64'hAB; start = 1'b1;
    tick(); start = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    chk("al_req", 64'(req), 64'd0);
    chk("al_done", 64'(done), 64'd1);
    chk("al_err", 64'(derr), 64'd1);
`else
    chk("al_req", 64'(req), 64'd1);
    chk("al_addr", addr, 64'h103);
    chk("al_we", 64'(we), 64'd1);
    chk("al_wdata", wdata, 64'hAB);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("al_done", 64'(done), 64'd1);
    chk("al_err", 64'(derr), 64'd0);
    chk("al_valM", valM, 64'h55);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
